bcd_field_counter: RTL and testbench
====================================

BCD_FIELD_COUNTER -- requirements
Module: bcd_field_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 24, field count range (legal 2..99, value runs 0..MODULUS-1).
REQ-002 SHALL have parameter BLANK_CODE, default 8'hBB, display code driven during the blink-off phase.
REQ-003 SHALL have port clk1  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ci  input  1  count tick/carry-in from the lower field, one cycle per count.
REQ-006 SHALL have port set_mode  input  1  1 = edit mode, 0 = run mode.
REQ-007 SHALL have port sel  input  1  this field selected for editing.
REQ-008 SHALL have port inc  input  1  single-cycle +1 edit pulse.
REQ-009 SHALL have port dec  input  1  single-cycle -1 edit pulse.
REQ-010 SHALL have port blink_tick  input  1  single-cycle pulse toggling blink phase.
REQ-011 SHALL have port value  output  8  registered BCD count, tens in [7:4], units in [3:0].
REQ-012 SHALL have port disp  output  8  display code: value or BLANK_CODE.
REQ-013 SHALL have port co  output  1  carry-out to the next field, combinational.

Function
REQ-014 SHALL implement a two-state FSM RUN/EDIT: RUN->EDIT when set_mode=1, EDIT->RUN when set_mode=0, evaluated every cycle.
REQ-015 SHALL in RUN with ci=1 increment value by one in BCD; units 9 -> 0 with tens+1; value MODULUS-1 -> 8'h00.
REQ-016 SHALL drive co = RUN & ci & (value == MODULUS-1) in the same cycle, so cascaded fields wrap on one edge.
REQ-017 SHALL in EDIT ignore ci and hold co = 0.
REQ-018 SHALL in EDIT with sel=1: inc alone -> +1 with wrap MODULUS-1 -> 0; dec alone -> -1 with wrap 0 -> MODULUS-1; inc and dec together -> no change; no co generated.
REQ-019 SHALL ignore inc/dec when sel=0 or in RUN.
REQ-020 SHALL keep value always a legal BCD code in 0..MODULUS-1; BLANK_CODE is never stored in value.
REQ-021 SHALL toggle a blink phase bit on blink_tick while EDIT & sel.
REQ-022 SHALL clear the blink phase on any accepted inc/dec, on sel=0, and on EDIT->RUN, so the edited value shows immediately.
REQ-023 SHALL drive disp = BLANK_CODE when EDIT & sel & phase=1, else disp = value.
REQ-024 SHALL retain value unchanged across RUN<->EDIT transitions.

Reset
REQ-025 SHALL on rst=1 at a clock edge set value = 8'h00, phase = 0 and state = RUN; rst overrides all other inputs.
REQ-026 SHALL hold co = 0 and disp = 8'h00 in the cycle after reset until inputs change.

Configuration
REQ-027 SHALL compile in blink support when macro BCD_FIELD_BLINK_EN is defined; REQ-021..REQ-023 then apply.
REQ-028 SHALL, without BCD_FIELD_BLINK_EN, omit the phase register, ignore blink_tick, and drive disp = value permanently.

Structure
REQ-029 SHALL place the bcd8_t typedef, the RUN/EDIT state enum and the default BLANK_CODE constant in shared package clock_pkg.
REQ-030 SHALL use one combinational sub-module, bcd_step, which computes BCD +/-1 with a parametric wrap limit; it is shared by run and edit paths.

Verification
REQ-031 SHALL check MODULUS=24, RUN, value 8'h23, ci=1 -> co=1 in the same cycle, value 8'h00 on the next edge.
REQ-032 SHALL check MODULUS=60, value 8'h09, ci=1 -> value 8'h10, co=0.
REQ-033 SHALL check EDIT, sel=1, value 8'h00, dec=1 -> value 8'h23 (MODULUS=24), co=0; then inc=1 -> 8'h00.
REQ-034 SHALL check EDIT, sel=1, blink_tick -> disp=8'hBB and value unchanged; then inc -> disp=new value on the next edge.
REQ-035 SHALL check EDIT with ci=1 at value 8'h23 -> value holds and co=0; inc=dec=1 -> value holds.
REQ-036 SHALL check rst=1 mid-EDIT with phase=1 -> value 8'h00, disp 8'h00, state RUN on the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-field counters.
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    typedef enum logic {
        StRun  = 1'b0,
        StEdit = 1'b1
    } field_state_e;

    localparam bcd8_t BLANK_CODE_DEFAULT = 8'hBB;

    // Binary (0..99) to packed two-digit BCD.
    function automatic bcd8_t to_bcd(input int unsigned n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational two-digit BCD +1/-1 with wrap at 0 and MODULUS-1.
module bcd_step
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS = 24
) (
    input  logic [7:0] i_value,
    input  logic       i_up,
    output logic [7:0] o_value,
    output logic       o_wrap
);

    localparam bcd8_t LAST = to_bcd(MODULUS - 1);

    always_comb begin
        o_value = i_value;
        o_wrap  = 1'b0;
        if (i_up) begin
            if (i_value == LAST) begin
                o_value = 8'h00;
                o_wrap  = 1'b1;
            end else if (i_value[3:0] == 4'd9) begin
                o_value = {i_value[7:4] + 4'd1, 4'd0};
            end else begin
                o_value = {i_value[7:4], i_value[3:0] + 4'd1};
            end
        end else begin
            if (i_value == 8'h00) begin
                o_value = LAST;
                o_wrap  = 1'b1;
            end else if (i_value[3:0] == 4'd0) begin
                o_value = {i_value[7:4] - 4'd1, 4'd9};
            end else begin
                o_value = {i_value[7:4], i_value[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/bcd_field_counter.sv
// One BCD field of a clock (e.g. hours/minutes) with run/edit modes.
// Blink-on-edit display is compiled in when BCD_FIELD_BLINK_EN is defined.
module bcd_field_counter
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS    = 24,
    parameter logic [7:0]  BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       ci,
    input  logic       set_mode,
    input  logic       sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       blink_tick,
    output logic [7:0] value,
    output logic [7:0] disp,
    output logic       co
);

    field_state_e r_state;
    field_state_e w_state_next;
    logic [7:0]   r_value;
    logic [7:0]   w_value_next;
    logic [7:0]   w_step_value;
    logic         w_step_wrap;
    logic         w_step_up;
    logic         w_run_tick;
    logic         w_edit_sel;
    logic         w_edit_step;

    assign w_run_tick  = (r_state == StRun) && ci;
    assign w_edit_sel  = (r_state == StEdit) && sel;
    assign w_edit_step = w_edit_sel && (inc ^ dec);
    // Run path always counts up; edit path direction follows the pulse.
    assign w_step_up   = (r_state == StRun) ? 1'b1 : inc;

    bcd_step #(
        .MODULUS (MODULUS)
    ) u_step (
        .i_value (r_value),
        .i_up    (w_step_up),
        .o_value (w_step_value),
        .o_wrap  (w_step_wrap)
    );

    always_comb begin
        w_state_next = set_mode ? StEdit : StRun;
        w_value_next = r_value;
        if (w_run_tick || w_edit_step) begin
            w_value_next = w_step_value;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= StRun;
            r_value <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_value <= w_value_next;
        end
    end

    assign value = r_value;
    assign co    = w_run_tick && w_step_wrap;

`ifdef BCD_FIELD_BLINK_EN
    logic r_phase;
    logic w_phase_next;

    always_comb begin
        w_phase_next = r_phase;
        // Leaving edit, deselecting or editing forces the value visible.
        if (!w_edit_sel || !set_mode || w_edit_step) begin
            w_phase_next = 1'b0;
        end else if (blink_tick) begin
            w_phase_next = ~r_phase;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    assign disp = (w_edit_sel && r_phase) ? BLANK_CODE : r_value;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink_tick;
    assign disp           = r_value;
`endif

endmodule

// File: tb/tb_bcd_field_counter.sv
// Scoreboard bench for bcd_field_counter: MODULUS=24 (inst 0) and MODULUS=60 (inst 1).
module tb_bcd_field_counter;

`ifdef BCD_FIELD_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] CI  = 7'b0100000;
    localparam logic [6:0] SM  = 7'b0010000;
    localparam logic [6:0] SEL = 7'b0001000;
    localparam logic [6:0] INC = 7'b0000100;
    localparam logic [6:0] DEC = 7'b0000010;
    localparam logic [6:0] BLK = 7'b0000001;
    localparam logic [6:0] NON = 7'b0000000;

    typedef struct packed {
        logic [15:0] tag;
        logic        inst;
        logic        chk;
        logic [7:0]  value;
        logic [7:0]  disp;
        logic        co;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b0, a_ci = 1'b0, a_sm = 1'b0, a_sel = 1'b0;
    logic       a_inc = 1'b0, a_dec = 1'b0, a_blk = 1'b0;
    logic       b_rst = 1'b0, b_ci = 1'b0, b_sm = 1'b0, b_sel = 1'b0;
    logic       b_inc = 1'b0, b_dec = 1'b0, b_blk = 1'b0;
    logic [7:0] a_value, a_disp, b_value, b_disp;
    logic       a_co, b_co;

    bcd_field_counter #(.MODULUS(24), .BLANK_CODE(8'hBB)) u_dut_a (
        .clk1(clk), .rst(a_rst), .ci(a_ci), .set_mode(a_sm), .sel(a_sel),
        .inc(a_inc), .dec(a_dec), .blink_tick(a_blk),
        .value(a_value), .disp(a_disp), .co(a_co)
    );

    bcd_field_counter #(.MODULUS(60), .BLANK_CODE(8'hBB)) u_dut_b (
        .clk1(clk), .rst(b_rst), .ci(b_ci), .set_mode(b_sm), .sel(b_sel),
        .inc(b_inc), .dec(b_dec), .blink_tick(b_blk),
        .value(b_value), .disp(b_disp), .co(b_co)
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] tag_cnt  = 16'd0;
    bit          done     = 1'b0;
    bit          final_checked = 1'b0;

    function automatic logic [7:0] bcd(input int i);
        return 8'(((i / 10) << 4) | (i % 10));
    endfunction

    function automatic logic [7:0] blanked(input logic [7:0] v);
        return BLINK ? 8'hBB : v;
    endfunction

    task automatic check(input logic [15:0] tag, input string what,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL step%0d %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Monitor: every driven cycle has one scoreboard entry, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk) begin
                check(e.tag, "value", e.inst ? b_value : a_value, e.value);
                check(e.tag, "disp",  e.inst ? b_disp  : a_disp,  e.disp);
                check(e.tag, "co",    {7'd0, e.inst ? b_co : a_co}, {7'd0, e.co});
            end
        end else if (done && !final_checked) begin
            final_checked = 1'b1;
            check(16'hFFFF, "sb_empty", 8'(sb_q.size()), 8'd0);
        end
    end

    task automatic cyc(input bit inst, input logic [6:0] in, input bit chk,
                       input logic [7:0] ev, input logic [7:0] ed, input logic ec);
        exp_t e;
        if (!inst) begin
            {a_rst, a_ci, a_sm, a_sel, a_inc, a_dec, a_blk} = in;
            {b_rst, b_ci, b_sm, b_sel, b_inc, b_dec, b_blk} = NON;
        end else begin
            {a_rst, a_ci, a_sm, a_sel, a_inc, a_dec, a_blk} = NON;
            {b_rst, b_ci, b_sm, b_sel, b_inc, b_dec, b_blk} = in;
        end
        tag_cnt++;
        e.tag = tag_cnt; e.inst = inst; e.chk = chk;
        e.value = ev; e.disp = ed; e.co = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // ---- instance A, MODULUS=24 ----
        cyc(0, RST,            0, 8'h00, 8'h00, 0);
        cyc(0, NON,            1, 8'h00, 8'h00, 0);   // reset state
        cyc(0, SM|SEL,         1, 8'h00, 8'h00, 0);
        cyc(0, SM|SEL|DEC,     1, 8'h00, 8'h00, 0);   // 00 -1 -> 23
        cyc(0, SM|SEL|CI,      1, 8'h23, 8'h23, 0);   // ci ignored in edit
        cyc(0, SM|SEL|INC|DEC, 1, 8'h23, 8'h23, 0);
        cyc(0, SM|SEL|INC,     1, 8'h23, 8'h23, 0);   // inc+dec held; 23 +1 -> 00
        cyc(0, SM|SEL|BLK,     1, 8'h00, 8'h00, 0);
        cyc(0, SM|SEL|INC,     1, 8'h00, blanked(8'h00), 0);
        cyc(0, SM|SEL,         1, 8'h01, 8'h01, 0);   // inc clears blink phase
        cyc(0, SM|SEL|BLK,     1, 8'h01, 8'h01, 0);
        cyc(0, SM,             1, 8'h01, 8'h01, 0);   // deselected shows value
        cyc(0, SM|INC,         1, 8'h01, 8'h01, 0);
        cyc(0, SM|BLK,         1, 8'h01, 8'h01, 0);   // inc ignored without sel
        cyc(0, SM|SEL|BLK,     1, 8'h01, 8'h01, 0);
        cyc(0, SEL,            1, 8'h01, blanked(8'h01), 0);
        cyc(0, SEL|INC,        1, 8'h01, 8'h01, 0);   // back in run, phase cleared
        cyc(0, CI,             1, 8'h01, 8'h01, 0);   // inc ignored in run
        cyc(0, SM,             1, 8'h02, 8'h02, 0);
        cyc(0, SM|SEL|DEC,     1, 8'h02, 8'h02, 0);
        cyc(0, SM|SEL|DEC,     1, 8'h01, 8'h01, 0);
        cyc(0, SM|SEL|DEC,     1, 8'h00, 8'h00, 0);
        cyc(0, NON,            1, 8'h23, 8'h23, 0);
        cyc(0, CI,             1, 8'h23, 8'h23, 1);   // terminal carry same cycle
        cyc(0, NON,            1, 8'h00, 8'h00, 0);
        cyc(0, SM|SEL,         1, 8'h00, 8'h00, 0);
        cyc(0, SM|SEL|INC,     1, 8'h00, 8'h00, 0);
        cyc(0, SM|SEL|BLK,     1, 8'h01, 8'h01, 0);
        cyc(0, RST|SM|SEL|INC, 1, 8'h01, blanked(8'h01), 0);
        cyc(0, CI,             1, 8'h00, 8'h00, 0);   // reset: RUN, 00
        cyc(0, NON,            1, 8'h01, 8'h01, 0);
        // ---- instance B, MODULUS=60 ----
        cyc(1, RST,            0, 8'h00, 8'h00, 0);
        cyc(1, SEL|DEC,        1, 8'h00, 8'h00, 0);   // dec ignored in run
        cyc(1, NON,            1, 8'h00, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(1, CI, 1, bcd(i), bcd(i), 0);
        end
        cyc(1, CI,             1, 8'h09, 8'h09, 0);
        cyc(1, SM,             1, 8'h10, 8'h10, 0);   // units carry into tens
        cyc(1, SM|SEL|DEC,     1, 8'h10, 8'h10, 0);
        cyc(1, SM|SEL|INC,     1, 8'h09, 8'h09, 0);   // borrow from tens
        cyc(1, SM|SEL|DEC,     1, 8'h10, 8'h10, 0);
        cyc(1, NON,            1, 8'h09, 8'h09, 0);
        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        if (!final_checked) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: queue %0d not drained", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
